// File: rtl/matmul_pkg.sv
// Shared types and default dimensions for the matrix-multiplier datapath.
package matmul_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefN         = 8;
  localparam int unsigned DefP         = 9;
  localparam int unsigned DefM         = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRowReq,
    StIssue,
    StStream,
    StWaitDone,
    StFinish
  } state_e;

  // Counter width for a counter running 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/col_streamer_if.sv
// B-memory read port: request/address out, stall/data back with one-cycle latency.
interface col_streamer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_stall;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_stall, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_stall, output mem_rdata);
endinterface

// File: rtl/col_streamer_addr_gen.sv
// Entry (k) and column counters for column-major B addressing: addr = col*N + k.
module addr_gen
  import matmul_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned M          = DefM,
  parameter int unsigned ADDR_WIDTH = $clog2(N*M)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  k_clr,
  input  logic                  k_inc,
  input  logic                  col_clr,
  input  logic                  col_inc,
  output logic                  k_zero,
  output logic                  k_last,
  output logic                  col_last,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned KW = cnt_width(N);
  localparam int unsigned CW = cnt_width(M);

  logic [KW-1:0] k_q;
  logic [CW-1:0] col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      col_q <= '0;
    end else begin
      if (k_clr)                k_q <= '0;
      else if (k_inc && !k_last) k_q <= k_q + 1'b1;
      if (col_clr)                  col_q <= '0;
      else if (col_inc && !col_last) col_q <= col_q + 1'b1;
    end
  end

  always_comb begin
    k_zero   = (k_q == '0);
    k_last   = (k_q == KW'(N - 1));
    col_last = (col_q == CW'(M - 1));
    addr     = ADDR_WIDTH'(32'(col_q) * N + 32'(k_q));
  end

endmodule

// File: rtl/col_streamer.sv
// Streams B columns to the PE array, one A row at a time, with memory stall and queue backpressure.
module col_streamer
  import matmul_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned P          = DefP,
  parameter int unsigned M          = DefM,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = $clog2(N*M)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  output logic                  busy,
  output logic                  job_done,
  output logic                  row_req,
  input  logic                  row_valid,
  col_streamer_if.master        mem,
  output logic                  load_row,
  output logic                  start_pe,
  output logic [DATA_WIDTH-1:0] col_entry,
  output logic                  col_valid,
  input  logic                  pe_done,
  input  logic                  fifo_full
);

  localparam int unsigned RW = cnt_width(P);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q;
  logic            row_last, row_clr, row_inc;
  logic            col_valid_q, accept, rd_en;
  logic            k_clr, k_inc, col_clr, col_inc;
  logic            k_zero, k_last, col_last;
  logic [ADDR_WIDTH-1:0] gen_addr;

  addr_gen #(
    .N          (N),
    .M          (M),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .k_clr    (k_clr),
    .k_inc    (k_inc),
    .col_clr  (col_clr),
    .col_inc  (col_inc),
    .k_zero   (k_zero),
    .k_last   (k_last),
    .col_last (col_last),
    .addr     (gen_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_valid_q <= accept;
      if (row_clr)                  row_q <= '0;
      else if (row_inc && !row_last) row_q <= row_q + 1'b1;
    end
  end

  assign row_last = (row_q == RW'(P - 1));

  always_comb begin
    state_d  = state_q;
    row_req  = 1'b0;
    load_row = 1'b0;
    start_pe = 1'b0;
    job_done = 1'b0;
    rd_en    = 1'b0;
    accept   = 1'b0;
    k_clr    = 1'b0;
    k_inc    = 1'b0;
    col_clr  = 1'b0;
    col_inc  = 1'b0;
    row_clr  = 1'b0;
    row_inc  = 1'b0;
    unique case (state_q)
      StIdle: if (go) state_d = StRowReq;
      StRowReq: begin
        row_req = 1'b1;
        if (row_valid) begin
          load_row = 1'b1;
          col_clr  = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (!fifo_full) begin
          k_clr   = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        rd_en  = 1'b1;
        accept = !mem.mem_stall;
        if (accept) begin
          k_inc    = 1'b1;
          start_pe = k_zero;
          if (k_last) state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (pe_done) begin
          if (!col_last) begin
            col_inc = 1'b1;
            state_d = StIssue;
          end else if (!row_last) begin
            row_inc = 1'b1;
            state_d = StRowReq;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        job_done = 1'b1;
        row_clr  = 1'b1;
        col_clr  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address and data are forced to zero outside their valid cycles so idle outputs stay quiet.
  assign busy          = (state_q != StIdle);
  assign mem.mem_rd_en = rd_en;
  assign mem.mem_addr  = rd_en ? gen_addr : '0;
  assign col_valid     = col_valid_q;
  assign col_entry     = col_valid_q ? mem.mem_rdata : '0;

endmodule

// File: tb/tb_col_streamer.sv
// Directed bench for col_streamer with N=2, M=2, P=2 and a one-cycle-latency B memory model.
module tb_col_streamer;

  logic        clk = 1'b0;
  logic        rst_n, go, row_valid, pe_done, fifo_full;
  logic        busy, job_done, row_req, load_row, start_pe, col_valid;
  logic [15:0] col_entry;
  int          errors = 0;
  int          checks = 0;
  int          beats = 0, starts = 0, loads = 0;

  col_streamer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) mif ();

  col_streamer #(
    .N          (2),
    .P          (2),
    .M          (2),
    .DATA_WIDTH (16),
    .ADDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .busy      (busy),
    .job_done  (job_done),
    .row_req   (row_req),
    .row_valid (row_valid),
    .mem       (mif.master),
    .load_row  (load_row),
    .start_pe  (start_pe),
    .col_entry (col_entry),
    .col_valid (col_valid),
    .pe_done   (pe_done),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mif.mem_rd_en && !mif.mem_stall) mif.mem_rdata <= 16'hA000 + 16'(mif.mem_addr);

  always @(negedge clk) begin
    if (col_valid) beats++;
    if (start_pe)  starts++;
    if (load_row)  loads++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; row_valid = 1'b0; pe_done = 1'b0; fifo_full = 1'b0;
    mif.mem_stall = 1'b0;
    #23;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mif.mem_addr), 0);
    chk("rst_rd_en", 32'(mif.mem_rd_en), 0);
    chk("rst_col_valid", 32'(col_valid), 0);
    chk("rst_col_entry", 32'(col_entry), 0);
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk("idle_row_req", 32'(row_req), 0);
    chk("idle_busy", 32'(busy), 0);
    go = 1'b1; #1;
    chk("go_sampled_idle", 32'(busy), 0);
    // Row 0: request row, held off one cycle by row_valid.
    cyc(); go = 1'b0; #1;
    chk("rowreq_req", 32'(row_req), 1);
    chk("rowreq_busy", 32'(busy), 1);
    chk("rowreq_noload", 32'(load_row), 0);
    cyc(); row_valid = 1'b1; #1;
    chk("rowreq_load", 32'(load_row), 1);
    // ISSUE with queue full for 5 cycles plus a spurious pe_done.
    cyc(); row_valid = 1'b0; fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pe_done = (i == 2); #1;
      chk("issue_full_rd_en", 32'(mif.mem_rd_en), 0);
      chk("issue_full_no_start", 32'(start_pe), 0);
      cyc();
    end
    pe_done = 1'b0; fifo_full = 1'b0; #1;
    chk("issue_release_rd_en", 32'(mif.mem_rd_en), 0);
    cyc(); fifo_full = 1'b1; #1;
    chk("c0_k0_rd_en", 32'(mif.mem_rd_en), 1);
    chk("c0_k0_addr", 32'(mif.mem_addr), 0);
    chk("c0_k0_start", 32'(start_pe), 1);
    // k=1 stalled for 3 cycles.
    cyc(); mif.mem_stall = 1'b1; #1;
    chk("c0_k1_addr", 32'(mif.mem_addr), 1);
    chk("c0_beat0_valid", 32'(col_valid), 1);
    chk("c0_beat0_data", 32'(col_entry), 32'hA000);
    chk("c0_k1_stall_nostart", 32'(start_pe), 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("stall_addr_hold", 32'(mif.mem_addr), 1);
      chk("stall_no_valid", 32'(col_valid), 0);
    end
    cyc(); mif.mem_stall = 1'b0; pe_done = 1'b1; #1;
    chk("stall_release_addr", 32'(mif.mem_addr), 1);
    chk("stall_release_rd_en", 32'(mif.mem_rd_en), 1);
    cyc(); pe_done = 1'b0; fifo_full = 1'b0; #1;
    chk("c0_wait_rd_en", 32'(mif.mem_rd_en), 0);
    chk("c0_beat1_data", 32'(col_entry), 32'hA001);
    chk("c0_wait_busy", 32'(busy), 1);
    cyc(); pe_done = 1'b1; #1;
    chk("c0_wait_hold_rd_en", 32'(mif.mem_rd_en), 0);
    cyc(); pe_done = 1'b0; #1;
    chk("c1_issue_rd_en", 32'(mif.mem_rd_en), 0);
    cyc(); #1;
    chk("c1_k0_addr", 32'(mif.mem_addr), 2);
    chk("c1_k0_start", 32'(start_pe), 1);
    cyc(); #1;
    chk("c1_k1_addr", 32'(mif.mem_addr), 3);
    chk("c1_beat0_data", 32'(col_entry), 32'hA002);
    cyc(); pe_done = 1'b1; #1;
    chk("c1_beat1_data", 32'(col_entry), 32'hA003);
    chk("row0_end_no_done", 32'(job_done), 0);
    // Row 1.
    cyc(); pe_done = 1'b0; #1;
    chk("row1_req", 32'(row_req), 1);
    chk("row1_no_done", 32'(job_done), 0);
    row_valid = 1'b1; #1;
    chk("row1_load", 32'(load_row), 1);
    cyc(); row_valid = 1'b0;
    cyc(); #1;
    chk("r1c0_k0_addr", 32'(mif.mem_addr), 0);
    cyc(); #1;
    chk("r1c0_k1_addr", 32'(mif.mem_addr), 1);
    cyc(); pe_done = 1'b1;
    cyc(); pe_done = 1'b0;
    cyc(); #1;
    chk("r1c1_k0_addr", 32'(mif.mem_addr), 2);
    cyc(); #1;
    chk("r1c1_k1_addr", 32'(mif.mem_addr), 3);
    cyc(); pe_done = 1'b1; #1;
    chk("r1_wait_no_done", 32'(job_done), 0);
    cyc(); pe_done = 1'b0; #1;
    chk("finish_done", 32'(job_done), 1);
    chk("finish_busy", 32'(busy), 1);
    cyc(); #1;
    chk("idle_after_done", 32'(job_done), 0);
    chk("idle_after_busy", 32'(busy), 0);
    chk("beats_total", 32'(beats), 8);
    chk("starts_total", 32'(starts), 4);
    chk("loads_total", 32'(loads), 2);
    // Reset mid-stream at k=1, then restart.
    go = 1'b1;
    cyc(); go = 1'b0; row_valid = 1'b1;
    cyc(); row_valid = 1'b0;
    cyc();
    cyc(); #1;
    chk("pre_rst_addr", 32'(mif.mem_addr), 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_rd_en", 32'(mif.mem_rd_en), 0);
    chk("rst_mid_addr", 32'(mif.mem_addr), 0);
    chk("rst_mid_valid", 32'(col_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_entry", 32'(col_entry), 0);
    cyc(); rst_n = 1'b1; go = 1'b1;
    cyc(); go = 1'b0; row_valid = 1'b1;
    cyc(); row_valid = 1'b0;
    cyc(); #1;
    chk("restart_addr", 32'(mif.mem_addr), 0);
    chk("restart_start", 32'(start_pe), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
